// File: rtl/dac_out.sv
// rtl/dac_out.sv - gain/offset DAC output stage with underrun and TLAST counters
// Optional ramp-down to zero on disable is enabled by defining DAC_OUT_RAMP_EN.
module dac_out #(
  parameter int DW = 14,
  parameter int MW = 16
) (
  input  logic          clk,
  input  logic          rstn,
  input  logic [DW-1:0] sti_tdata,
  input  logic          sti_tvalid,
  output logic          sti_tready,
  input  logic          sti_tlast,
  input  logic          cfg_ena,
  input  logic [MW-1:0] cfg_mul,
  input  logic [DW-1:0] cfg_sum,
  input  logic [DW-2:0] cfg_stp,
  input  logic          cfg_clr,
  output logic [DW-1:0] dac_dat,
  output logic          dac_vld,
  output logic [31:0]   sts_urn,
  output logic [31:0]   sts_lst
);

`ifdef DAC_OUT_RAMP_EN
  typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, RAMP = 2'd2} state_t;
`else
  typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1} state_t;
`endif

  state_t state, state_n;

  logic                      xfer;
  logic                      v1;
  logic signed [DW+MW-1:0]   prod;
  logic signed [DW+MW-1:0]   prod_q;
  logic signed [DW+MW-1:0]   prod_sh;
  logic signed [DW+MW:0]     acc;
  logic [DW-MW+MW:0]         acc_top_unused_guard;
  logic [MW+1:0]             acc_top;
  logic [DW-1:0]             sat_y;
  logic [DW-1:0]             y_q;
  logic [DW-1:0]             ramp_y;

  assign xfer = sti_tvalid & sti_tready;

  // Operands are sign-extended to the product width so the multiply keeps full precision.
  assign prod    = $signed({{MW{sti_tdata[DW-1]}}, sti_tdata}) * $signed({{DW{cfg_mul[MW-1]}}, cfg_mul});
  assign prod_sh = prod_q >>> (MW-2);
  assign acc     = $signed({prod_sh[DW+MW-1], prod_sh}) + $signed({{(MW+1){cfg_sum[DW-1]}}, cfg_sum});

  // In range only when every bit above the sample sign bit matches it.
  assign acc_top = acc[DW+MW:DW-1];
  assign acc_top_unused_guard = '0;

  always_comb begin
    sat_y = acc[DW-1:0];
    if (!((acc_top == '0) || (acc_top == '1))) begin
      if (acc[DW+MW]) sat_y = {1'b1, {(DW-1){1'b0}}};
      else            sat_y = {1'b0, {(DW-1){1'b1}}};
    end
  end

`ifdef DAC_OUT_RAMP_EN
  logic [DW-1:0] ramp_mag;
  logic [DW-1:0] stp_ext;

  assign ramp_mag = y_q[DW-1] ? (~y_q + 1'b1) : y_q;
  assign stp_ext  = {1'b0, cfg_stp};

  // Clamp at zero so the ramp never overshoots; a zero step snaps straight to zero.
  always_comb begin
    ramp_y = '0;
    if ((cfg_stp != '0) && (ramp_mag > stp_ext)) begin
      if (y_q[DW-1]) ramp_y = y_q + stp_ext;
      else           ramp_y = y_q - stp_ext;
    end
  end
`else
  logic unused_stp;
  assign unused_stp = ^cfg_stp;
  assign ramp_y     = '0;
`endif

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) state <= IDLE;
    else       state <= state_n;
  end

  always_comb begin
    state_n    = state;
    sti_tready = 1'b0;
    dac_vld    = 1'b0;
    case (state)
      IDLE: begin
        if (cfg_ena) state_n = RUN;
      end
      RUN: begin
        sti_tready = cfg_ena;
        dac_vld    = 1'b1;
`ifdef DAC_OUT_RAMP_EN
        if (!cfg_ena) state_n = RAMP;
`else
        if (!cfg_ena) state_n = IDLE;
`endif
      end
`ifdef DAC_OUT_RAMP_EN
      RAMP: begin
        dac_vld = 1'b1;
        if (y_q == '0) state_n = IDLE;
      end
`endif
      default: state_n = IDLE;
    endcase
  end

  // Stage 2 only commits while RUN stays enabled, which drops in-flight samples on exit.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      v1     <= 1'b0;
      prod_q <= '0;
      y_q    <= '0;
    end else begin
      v1 <= xfer;
      if (xfer) prod_q <= prod;
      case (state)
        RUN: begin
          if (v1 && cfg_ena) y_q <= sat_y;
        end
`ifdef DAC_OUT_RAMP_EN
        RAMP: y_q <= ramp_y;
`endif
        default: y_q <= '0;
      endcase
    end
  end

  assign dac_dat = (state == IDLE) ? {1'b1, {(DW-1){1'b0}}} : {~y_q[DW-1], y_q[DW-2:0]};

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      sts_urn <= '0;
      sts_lst <= '0;
    end else if (cfg_clr) begin
      sts_urn <= '0;
      sts_lst <= '0;
    end else begin
      if ((state == RUN) && !sti_tvalid && (sts_urn != '1)) sts_urn <= sts_urn + 32'd1;
      if (xfer && sti_tlast && (sts_lst != '1))             sts_lst <= sts_lst + 32'd1;
    end
  end

  logic unused_ramp;
  assign unused_ramp = ^{ramp_y, acc_top_unused_guard};

endmodule
